wb_irq_ctrl: RTL

Parametrised Wishbone-slave interrupt controller that replaces direct wiring of the core's 8-bit ext_irq_bus_i. It accepts NUM_IRQ asynchronous sources, each with per-source level/edge mode, enable and priority. It arbitrates the sources against a threshold and drives one interrupt line plus the winning ID to the core. Software uses a claim/complete handshake through memory-mapped registers.

---
 rtl/wb_irq_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/wb_irq_ctrl.sv
// Wishbone-slave interrupt controller: NUM_IRQ async sources with per-source
// level/edge mode, enable and priority, threshold gating and claim/complete.
//
// Ports:
//   CLK_I, RST_I        clock, asynchronous active-low reset
//   CYC_I, STB_I, WE_I  Wishbone cycle, strobe, write enable
//   ADR_I[7:0]          byte address, [7:2] decoded
//   DAT_I[31:0]         write data
//   SEL_I[3:0]          byte selects, any non-zero writes the whole register
//   DAT_O[31:0]         read data, non-zero only while ACK_O=1
//   ACK_O               registered one-cycle acknowledge
//   irq_src_i           raw interrupt sources (asynchronous)
//   irq_o, irq_id_o     registered request and winning ID (0 = none)
module wb_irq_ctrl #(
    parameter int NUM_IRQ = 8,
    parameter int PRIO_W  = 3
) (
    input  logic               CLK_I,
    input  logic               RST_I,
    input  logic               CYC_I,
    input  logic               STB_I,
    input  logic               WE_I,
    input  logic [7:0]         ADR_I,
    input  logic [31:0]        DAT_I,
    input  logic [3:0]         SEL_I,
    output logic [31:0]        DAT_O,
    output logic               ACK_O,
    input  logic [NUM_IRQ-1:0] irq_src_i,
    output logic               irq_o,
    output logic [5:0]         irq_id_o
);

    localparam logic [5:0] A_PEND  = 6'd0;
    localparam logic [5:0] A_EN    = 6'd1;
    localparam logic [5:0] A_MODE  = 6'd2;
    localparam logic [5:0] A_THR   = 6'd3;
    localparam logic [5:0] A_CLAIM = 6'd4;
    localparam logic [5:0] A_PRIO  = 6'd16;

    logic               r_ack;
    logic [31:0]        r_dat;
    logic [NUM_IRQ-1:0] r_sync1;
    logic [NUM_IRQ-1:0] r_sync2;
    logic [NUM_IRQ-1:0] r_sync2_d;
    logic [NUM_IRQ-1:0] r_pend;
    logic [NUM_IRQ-1:0] r_en;
    logic [NUM_IRQ-1:0] r_mode;
    logic [NUM_IRQ-1:0] r_insvc;
    logic [PRIO_W-1:0]  r_thr;
    logic [PRIO_W-1:0]  r_prio [NUM_IRQ];
    logic               r_irq;
    logic [5:0]         r_id;

    logic               w_req;
    logic               w_wr;
    logic               w_claim;
    logic               w_cmpl;
    logic [5:0]         w_adr;
    logic [NUM_IRQ-1:0] w_cand;
    logic [PRIO_W-1:0]  w_best;
    logic [5:0]         w_win_id;
    logic [NUM_IRQ-1:0] w_claim_mask;
    logic [NUM_IRQ-1:0] w_cmpl_mask;
    logic [NUM_IRQ-1:0] w_w1c;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_pend_nxt;
    logic [31:0]        w_rdata;
    logic               w_unused;

    assign w_adr    = ADR_I[7:2];
    assign w_unused = ^{ADR_I[1:0], DAT_I};

    // A held strobe is accepted only when no ACK is outstanding,
    // so back-to-back requests complete every other cycle.
    assign w_req   = CYC_I & STB_I & ~r_ack;
    assign w_wr    = w_req & WE_I & (|SEL_I);
    assign w_claim = w_req & ~WE_I & (w_adr == A_CLAIM);
    assign w_cmpl  = w_wr & (w_adr == A_CLAIM);

    assign w_rise = r_sync2 & ~r_sync2_d;
    assign w_w1c  = (w_wr && (w_adr == A_PEND))
                  ? (DAT_I[NUM_IRQ-1:0] & r_mode) : '0;

    // Edge sources: a new rising edge wins over a same-cycle clear.
    // Level sources simply track the synchronised input.
    assign w_pend_nxt =
        (r_mode & (w_rise | (r_pend & ~(w_claim_mask | w_w1c))))
      | (~r_mode & r_sync2);

    // Ascending scan with strict '>' keeps the lowest index on ties.
    always_comb begin
        w_cand   = '0;
        w_best   = '0;
        w_win_id = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_cand[i] = r_pend[i] & r_en[i] & ~r_insvc[i]
                      & (r_prio[i] > r_thr);
            if (w_cand[i] && (r_prio[i] > w_best)) begin
                w_best   = r_prio[i];
                w_win_id = 6'(i + 1);
            end
        end
    end

    // Unmatched IDs (0 or above NUM_IRQ) select no source.
    always_comb begin
        w_claim_mask = '0;
        w_cmpl_mask  = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_claim_mask[i] = w_claim && (w_win_id == 6'(i + 1));
            w_cmpl_mask[i]  = w_cmpl && (DAT_I[5:0] == 6'(i + 1));
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_adr)
            A_PEND:  w_rdata[NUM_IRQ-1:0] = r_pend;
            A_EN:    w_rdata[NUM_IRQ-1:0] = r_en;
            A_MODE:  w_rdata[NUM_IRQ-1:0] = r_mode;
            A_THR:   w_rdata[PRIO_W-1:0]  = r_thr;
            A_CLAIM: w_rdata[5:0]         = w_win_id;
            default: ;
        endcase
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (w_adr == A_PRIO + 6'(i)) begin
                w_rdata[PRIO_W-1:0] = r_prio[i];
            end
        end
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_ack     <= 1'b0;
            r_dat     <= '0;
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_sync2_d <= '0;
            r_pend    <= '0;
            r_en      <= '0;
            r_mode    <= '0;
            r_insvc   <= '0;
            r_thr     <= '0;
            r_irq     <= 1'b0;
            r_id      <= '0;
            for (int i = 0; i < NUM_IRQ; i++) begin
                r_prio[i] <= '0;
            end
        end else begin
            r_ack     <= w_req;
            r_dat     <= (w_req && !WE_I) ? w_rdata : '0;
            r_sync1   <= irq_src_i;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
            r_pend    <= w_pend_nxt;
            r_insvc   <= (r_insvc | w_claim_mask) & ~w_cmpl_mask;
            r_irq     <= (w_win_id != 6'd0);
            r_id      <= w_win_id;
            if (w_wr && (w_adr == A_EN)) begin
                r_en <= DAT_I[NUM_IRQ-1:0];
            end
            if (w_wr && (w_adr == A_MODE)) begin
                r_mode <= DAT_I[NUM_IRQ-1:0];
            end
            if (w_wr && (w_adr == A_THR)) begin
                r_thr <= DAT_I[PRIO_W-1:0];
            end
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (w_wr && (w_adr == A_PRIO + 6'(i))) begin
                    r_prio[i] <= DAT_I[PRIO_W-1:0];
                end
            end
        end
    end

    assign ACK_O    = r_ack;
    assign DAT_O    = r_dat;
    assign irq_o    = r_irq;
    assign irq_id_o = r_id;

endmodule
